// File: rtl/l2_multi_stream_control.sv
// l2_multi_stream_control
// Per-stream bookkeeping for several L2 prefetch streams that share one URAM
// read port and one OpenCAPI request port. Each stream keeps a read pointer,
// a request pointer, a count of valid lines and a count of outstanding
// requests. Requests are issued round-robin; L1 reads are accepted once
// enough lines are present. A stream can be functionally restarted at any
// line once none of its requests are in flight.
module l2_multi_stream_control #(
    parameter int NSTREAMS  = 8,
    parameter int L2_NCL    = 256,
    parameter int L2_MIN_CL = 1,
    parameter int SID_W     = (NSTREAMS > 1) ? $clog2(NSTREAMS) : 1,
    parameter int NCL_W     = $clog2(L2_NCL),
    parameter int CNT_W     = $clog2(L2_NCL + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_rst_v,
    output logic                i_rst_r,
    input  logic [SID_W-1:0]    i_rst_sid,
    input  logic [NCL_W-1:0]    i_rst_ptr,
    input  logic                i_rd_v,
    output logic                i_rd_r,
    input  logic [SID_W-1:0]    i_rd_sid,
    output logic                o_addr_v,
    input  logic                o_addr_r,
    output logic [SID_W-1:0]    o_addr_sid,
    output logic [NCL_W-1:0]    o_addr_ptr,
    output logic                o_req_v,
    input  logic                o_req_r,
    output logic [SID_W-1:0]    o_req_sid,
    output logic [NCL_W-1:0]    o_req_ptr,
    input  logic                i_rsp_v,
    output logic                i_rsp_r,
    input  logic [SID_W-1:0]    i_rsp_sid,
    output logic [NSTREAMS-1:0] o_active,
    output logic                o_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } stream_state_e;

    localparam logic [CNT_W:0]   NCL_EXT = (CNT_W + 1)'(L2_NCL);
    localparam logic [CNT_W-1:0] MIN_CL  = CNT_W'(L2_MIN_CL);

    // Per-stream state
    stream_state_e    state_r      [NSTREAMS];
    stream_state_e    state_nxt_s  [NSTREAMS];
    logic [NCL_W-1:0] rd_ptr_r     [NSTREAMS];
    logic [NCL_W-1:0] rd_ptr_nxt_s [NSTREAMS];
    logic [NCL_W-1:0] req_ptr_r    [NSTREAMS];
    logic [NCL_W-1:0] req_ptr_nxt_s[NSTREAMS];
    logic [CNT_W-1:0] valid_r      [NSTREAMS];
    logic [CNT_W-1:0] valid_nxt_s  [NSTREAMS];
    logic [CNT_W-1:0] outst_r      [NSTREAMS];
    logic [CNT_W-1:0] outst_nxt_s  [NSTREAMS];

    // Arbiter state
    logic [SID_W-1:0] rr_r;
    logic             lock_r;
    logic [SID_W-1:0] lock_sid_r;

    // Registered URAM read request and sticky error
    logic             addr_v_r;
    logic [SID_W-1:0] addr_sid_r;
    logic [NCL_W-1:0] addr_ptr_r;
    logic             err_r;

    // Combinational control
    logic [NSTREAMS-1:0] cand_s;
    logic                arb_found_s;
    logic [SID_W-1:0]    arb_sid_s;
    logic [SID_W-1:0]    arb_idx_s;
    logic                req_v_s;
    logic [SID_W-1:0]    req_sid_s;
    logic                req_hs_s;
    logic [SID_W-1:0]    rr_inc_s;
    logic                rst_rdy_s;
    logic                rst_acc_s;
    logic                rd_rdy_s;
    logic                rd_acc_s;
    logic                rsp_err_s;
    logic [NSTREAMS-1:0] rst_hit_s;
    logic [NSTREAMS-1:0] rd_hit_s;
    logic [NSTREAMS-1:0] rsp_hit_s;
    logic [NSTREAMS-1:0] req_hit_s;

    // A stream may request when running and holding fewer than L2_NCL lines
    always_comb begin
        cand_s = '0;
        for (int s = 0; s < NSTREAMS; s++) begin
            if ((state_r[s] == ST_RUN) &&
                (({1'b0, valid_r[s]} + {1'b0, outst_r[s]}) < NCL_EXT)) begin
                cand_s[s] = 1'b1;
            end else begin
                cand_s[s] = 1'b0;
            end
        end
    end

    // Round-robin search starting at rr; a stalled grant stays locked
    always_comb begin
        arb_found_s = 1'b0;
        arb_sid_s   = '0;
        arb_idx_s   = '0;
        for (int k = 0; k < NSTREAMS; k++) begin
            arb_idx_s = SID_W'((32'(rr_r) + 32'(k)) % 32'(NSTREAMS));
            if (!arb_found_s && cand_s[arb_idx_s]) begin
                arb_found_s = 1'b1;
                arb_sid_s   = arb_idx_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        if (lock_r) begin
            req_v_s   = 1'b1;
            req_sid_s = lock_sid_r;
        end else begin
            req_v_s   = arb_found_s;
            req_sid_s = arb_sid_s;
        end
        req_hs_s = req_v_s && o_req_r;
        if (req_sid_s == SID_W'(NSTREAMS - 1)) begin
            rr_inc_s = '0;
        end else begin
            rr_inc_s = req_sid_s + SID_W'(1);
        end
    end

    // Handshake qualification for functional reset, L1 read and response
    always_comb begin
        rst_rdy_s = (outst_r[i_rst_sid] == '0) &&
                    !(req_v_s && (req_sid_s == i_rst_sid));
        rst_acc_s = i_rst_v && rst_rdy_s;
        rd_rdy_s  = (valid_r[i_rd_sid] >= MIN_CL) &&
                    (!addr_v_r || o_addr_r) &&
                    !(i_rst_v && (i_rst_sid == i_rd_sid));
        rd_acc_s  = i_rd_v && rd_rdy_s;
        rsp_err_s = i_rsp_v && (outst_r[i_rsp_sid] == '0);
        for (int s = 0; s < NSTREAMS; s++) begin
            rst_hit_s[s] = rst_acc_s && (i_rst_sid == SID_W'(s));
            rd_hit_s[s]  = rd_acc_s && (i_rd_sid == SID_W'(s));
            rsp_hit_s[s] = i_rsp_v && (i_rsp_sid == SID_W'(s)) && (outst_r[s] != '0);
            req_hit_s[s] = req_hs_s && (req_sid_s == SID_W'(s));
        end
    end

    // Per-stream FSM and counter next-state; a functional reset overrides all
    always_comb begin
        for (int s = 0; s < NSTREAMS; s++) begin
            state_nxt_s[s]   = state_r[s];
            rd_ptr_nxt_s[s]  = rd_ptr_r[s];
            req_ptr_nxt_s[s] = req_ptr_r[s];
            valid_nxt_s[s]   = valid_r[s];
            outst_nxt_s[s]   = outst_r[s];

            case (state_r[s])
                ST_IDLE: begin
                    if (rst_hit_s[s]) begin
                        state_nxt_s[s] = ST_RUN;
                    end else begin
                        state_nxt_s[s] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    state_nxt_s[s] = ST_RUN;
                end
                default: begin
                    state_nxt_s[s] = ST_IDLE;
                end
            endcase

            if (rst_hit_s[s]) begin
                rd_ptr_nxt_s[s]  = i_rst_ptr;
                req_ptr_nxt_s[s] = i_rst_ptr;
                valid_nxt_s[s]   = '0;
            end else begin
                if (rd_hit_s[s]) begin
                    rd_ptr_nxt_s[s] = rd_ptr_r[s] + NCL_W'(1);
                end else begin
                    rd_ptr_nxt_s[s] = rd_ptr_r[s];
                end
                if (req_hit_s[s]) begin
                    req_ptr_nxt_s[s] = req_ptr_r[s] + NCL_W'(1);
                end else begin
                    req_ptr_nxt_s[s] = req_ptr_r[s];
                end
                // Simultaneous arrival and consumption leave the count as is
                case ({rsp_hit_s[s], rd_hit_s[s]})
                    2'b10:   valid_nxt_s[s] = valid_r[s] + CNT_W'(1);
                    2'b01:   valid_nxt_s[s] = valid_r[s] - CNT_W'(1);
                    default: valid_nxt_s[s] = valid_r[s];
                endcase
                case ({req_hit_s[s], rsp_hit_s[s]})
                    2'b10:   outst_nxt_s[s] = outst_r[s] + CNT_W'(1);
                    2'b01:   outst_nxt_s[s] = outst_r[s] - CNT_W'(1);
                    default: outst_nxt_s[s] = outst_r[s];
                endcase
            end
        end
    end

    // Per-stream state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSTREAMS; s++) begin
                state_r[s]   <= ST_IDLE;
                rd_ptr_r[s]  <= '0;
                req_ptr_r[s] <= '0;
                valid_r[s]   <= '0;
                outst_r[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < NSTREAMS; s++) begin
                state_r[s]   <= state_nxt_s[s];
                rd_ptr_r[s]  <= rd_ptr_nxt_s[s];
                req_ptr_r[s] <= req_ptr_nxt_s[s];
                valid_r[s]   <= valid_nxt_s[s];
                outst_r[s]   <= outst_nxt_s[s];
            end
        end
    end

    // Round-robin pointer advances past the stream that just handshook
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_r <= '0;
        end else if (req_hs_s) begin
            rr_r <= rr_inc_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Hold the grant while the request port is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_r     <= 1'b0;
            lock_sid_r <= '0;
        end else if (req_v_s && !o_req_r) begin
            lock_r     <= 1'b1;
            lock_sid_r <= req_sid_s;
        end else begin
            lock_r     <= 1'b0;
            lock_sid_r <= lock_sid_r;
        end
    end

    // URAM read output: load on accepted read, hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_v_r   <= 1'b0;
            addr_sid_r <= '0;
            addr_ptr_r <= '0;
        end else if (rd_acc_s) begin
            addr_v_r   <= 1'b1;
            addr_sid_r <= i_rd_sid;
            addr_ptr_r <= rd_ptr_r[i_rd_sid];
        end else if (o_addr_r) begin
            addr_v_r   <= 1'b0;
            addr_sid_r <= addr_sid_r;
            addr_ptr_r <= addr_ptr_r;
        end else begin
            addr_v_r   <= addr_v_r;
            addr_sid_r <= addr_sid_r;
            addr_ptr_r <= addr_ptr_r;
        end
    end

    // Sticky flag for a response that matches no outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (rsp_err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Running-stream indication decoded from the per-stream FSMs
    always_comb begin
        o_active = '0;
        for (int s = 0; s < NSTREAMS; s++) begin
            if (state_r[s] == ST_RUN) begin
                o_active[s] = 1'b1;
            end else begin
                o_active[s] = 1'b0;
            end
        end
    end

    assign i_rst_r    = rst_rdy_s;
    assign i_rd_r     = rd_rdy_s;
    assign i_rsp_r    = 1'b1;
    assign o_addr_v   = addr_v_r;
    assign o_addr_sid = addr_sid_r;
    assign o_addr_ptr = addr_ptr_r;
    assign o_req_v    = req_v_s;
    assign o_req_sid  = req_sid_s;
    assign o_req_ptr  = req_ptr_r[req_sid_s];
    assign o_err      = err_r;

endmodule

// File: tb/tb_l2_multi_stream_control.sv
// Scoreboard bench for l2_multi_stream_control: expected URAM reads and
// OpenCAPI requests are queued when stimulus is driven and compared when the
// design presents them.
module tb_l2_multi_stream_control;

    localparam int NSTREAMS  = 8;
    localparam int L2_NCL    = 256;
    localparam int L2_MIN_CL = 1;
    localparam int SID_W     = 3;
    localparam int NCL_W     = 8;
    localparam int CNT_W     = 9;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_rst_v;
    logic                i_rst_r;
    logic [SID_W-1:0]    i_rst_sid;
    logic [NCL_W-1:0]    i_rst_ptr;
    logic                i_rd_v;
    logic                i_rd_r;
    logic [SID_W-1:0]    i_rd_sid;
    logic                o_addr_v;
    logic                o_addr_r;
    logic [SID_W-1:0]    o_addr_sid;
    logic [NCL_W-1:0]    o_addr_ptr;
    logic                o_req_v;
    logic                o_req_r;
    logic [SID_W-1:0]    o_req_sid;
    logic [NCL_W-1:0]    o_req_ptr;
    logic                i_rsp_v;
    logic                i_rsp_r;
    logic [SID_W-1:0]    i_rsp_sid;
    logic [NSTREAMS-1:0] o_active;
    logic                o_err;

    int check_cnt = 0;
    int error_cnt = 0;

    logic [10:0] addr_q[$];
    logic [10:0] req_q[$];
    logic [10:0] addr_exp;

    l2_multi_stream_control #(
        .NSTREAMS (NSTREAMS),
        .L2_NCL   (L2_NCL),
        .L2_MIN_CL(L2_MIN_CL),
        .SID_W    (SID_W),
        .NCL_W    (NCL_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_rst_v   (i_rst_v),
        .i_rst_r   (i_rst_r),
        .i_rst_sid (i_rst_sid),
        .i_rst_ptr (i_rst_ptr),
        .i_rd_v    (i_rd_v),
        .i_rd_r    (i_rd_r),
        .i_rd_sid  (i_rd_sid),
        .o_addr_v  (o_addr_v),
        .o_addr_r  (o_addr_r),
        .o_addr_sid(o_addr_sid),
        .o_addr_ptr(o_addr_ptr),
        .o_req_v   (o_req_v),
        .o_req_r   (o_req_r),
        .o_req_sid (o_req_sid),
        .o_req_ptr (o_req_ptr),
        .i_rsp_v   (i_rsp_v),
        .i_rsp_r   (i_rsp_r),
        .i_rsp_sid (i_rsp_sid),
        .o_active  (o_active),
        .o_err     (o_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every URAM read the design issues against the queued expectation
    always @(negedge clk) begin
        if (!reset && o_addr_v && o_addr_r) begin
            if (addr_q.size() == 0) begin
                check_val("addr_unexpected", {21'd0, o_addr_sid, o_addr_ptr}, 32'hFFFF_FFFF);
            end else begin
                addr_exp = addr_q.pop_front();
                check_val("addr", {21'd0, o_addr_sid, o_addr_ptr}, {21'd0, addr_exp});
            end
        end
    end

    // Functional stream reset with a bounded wait for acceptance
    task automatic stream_rst(input logic [SID_W-1:0] sid, input logic [NCL_W-1:0] ptr);
        bit done;
        done      = 1'b0;
        i_rst_v   = 1'b1;
        i_rst_sid = sid;
        i_rst_ptr = ptr;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (i_rst_r) done = 1'b1;
            step();
        end
        i_rst_v = 1'b0;
        check_val("rst_accept", {31'd0, done}, 32'd1);
    endtask

    // Open the request port for n cycles, expecting a handshake every cycle
    task automatic req_drain(input int n);
        logic [10:0] e;
        o_req_r = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (req_q.size() == 0) begin
                check_val("req_unexpected", {20'd0, o_req_v, o_req_sid, o_req_ptr}, 32'hFFFF_FFFF);
            end else begin
                e = req_q.pop_front();
                check_val("req", {20'd0, o_req_v, o_req_sid, o_req_ptr}, {20'd0, 1'b1, e});
            end
            step();
        end
        o_req_r = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        i_rst_v   = 1'b0;
        i_rst_sid = '0;
        i_rst_ptr = '0;
        i_rd_v    = 1'b0;
        i_rd_sid  = '0;
        o_addr_r  = 1'b1;
        o_req_r   = 1'b0;
        i_rsp_v   = 1'b0;
        i_rsp_sid = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Quiet after reset
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_val("idle_req_v", {31'd0, o_req_v}, 32'd0);
            check_val("idle_rd_r", {31'd0, i_rd_r}, 32'd0);
            check_val("idle_active", {24'd0, o_active}, 32'd0);
            check_val("idle_err", {31'd0, o_err}, 32'd0);
            check_val("idle_addr_v", {31'd0, o_addr_v}, 32'd0);
            step();
        end

        // Stream 2 from line 250: 256 requests wrapping through 0
        stream_rst(3'd2, 8'd250);
        for (int i = 0; i < 256; i++) req_q.push_back({3'd2, 8'(250 + i)});
        req_drain(256);
        @(negedge clk);
        check_val("s2_full_req_v", {31'd0, o_req_v}, 32'd0);
        check_val("s2_active", {24'd0, o_active}, 32'h04);
        step();

        // Three responses allow exactly three reads
        i_rsp_v   = 1'b1;
        i_rsp_sid = 3'd2;
        repeat (3) step();
        i_rsp_v  = 1'b0;
        i_rd_v   = 1'b1;
        i_rd_sid = 3'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("s2_rd_r", {31'd0, i_rd_r}, {31'd0, (k < 3)});
            if (k < 3) addr_q.push_back({3'd2, 8'(250 + k)});
            step();
        end
        i_rd_v = 1'b0;
        // Freed lines are refetched at the wrapped request pointer
        for (int i = 0; i < 3; i++) req_q.push_back({3'd2, 8'(250 + i)});
        req_drain(3);
        @(negedge clk);
        check_val("s2_refill_req_v", {31'd0, o_req_v}, 32'd0);
        step();

        // Streams 0,1,3 share the request port round-robin
        stream_rst(3'd0, 8'd10);
        stream_rst(3'd1, 8'd20);
        stream_rst(3'd3, 8'd30);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("req_hold", {20'd0, o_req_v, o_req_sid, o_req_ptr}, {20'd0, 1'b1, 3'd0, 8'd10});
            step();
        end
        for (int i = 0; i < 5; i++) begin
            req_q.push_back({3'd0, 8'(10 + i)});
            req_q.push_back({3'd1, 8'(20 + i)});
            req_q.push_back({3'd3, 8'(30 + i)});
        end
        req_drain(15);
        @(negedge clk);
        check_val("rr_active", {24'd0, o_active}, 32'h0F);
        step();

        // Reset of stream 2 waits for its last outstanding response
        i_rsp_v   = 1'b1;
        i_rsp_sid = 3'd2;
        repeat (255) step();
        i_rsp_v   = 1'b0;
        i_rst_v   = 1'b1;
        i_rst_sid = 3'd2;
        i_rst_ptr = 8'd100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("s2_rst_blocked", {31'd0, i_rst_r}, 32'd0);
            step();
        end
        i_rsp_v = 1'b1;
        @(negedge clk);
        check_val("s2_rst_blocked_rsp", {31'd0, i_rst_r}, 32'd0);
        step();
        i_rsp_v = 1'b0;
        @(negedge clk);
        check_val("s2_rst_ready", {31'd0, i_rst_r}, 32'd1);
        step();
        i_rst_v  = 1'b0;
        i_rd_v   = 1'b1;
        i_rd_sid = 3'd2;
        @(negedge clk);
        check_val("s2_rd_after_rst", {31'd0, i_rd_r}, 32'd0);
        step();
        i_rd_v = 1'b0;

        // Response with nothing outstanding raises a sticky error
        @(negedge clk);
        check_val("err_before", {31'd0, o_err}, 32'd0);
        step();
        i_rsp_v   = 1'b1;
        i_rsp_sid = 3'd4;
        step();
        i_rsp_v = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("err_sticky", {31'd0, o_err}, 32'd1);
            check_val("err_active", {24'd0, o_active}, 32'h0F);
            step();
        end

        // Stream 0: four lines, then a read and a response in the same cycle
        i_rsp_v   = 1'b1;
        i_rsp_sid = 3'd0;
        repeat (4) step();
        i_rd_v   = 1'b1;
        i_rd_sid = 3'd0;
        @(negedge clk);
        check_val("s0_rd_rsp_r", {31'd0, i_rd_r}, 32'd1);
        addr_q.push_back({3'd0, 8'd10});
        step();
        i_rsp_v = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("s0_rd_r", {31'd0, i_rd_r}, {31'd0, (k < 4)});
            if (k < 4) addr_q.push_back({3'd0, 8'(11 + k)});
            step();
        end
        i_rd_v = 1'b0;
        repeat (3) step();

        check_val("addr_q_left", addr_q.size(), 32'd0);
        check_val("req_q_left", req_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
